// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline hazard sequencer: load-use stall, branch squash, memory wait freeze
//
// Optional feature macro: HAZARD_CTRL_STALL_COUNT_EN enables the stall-cycle counter.
//
// Ports:
//   clk_i, rst_ni                    clock, asynchronous active-low reset
//   id_sel_rs1_i/id_sel_rs2_i        source register pointers of the instruction in ID
//   id_uses_rs1_i/id_uses_rs2_i      ID instruction actually reads rs1/rs2
//   ex_sel_rd_i, ex_is_load_i        destination pointer and load flag of the instruction in EX
//   ex_branch_taken_i                EX resolved a taken branch/jump
//   mem_req_i, mem_ready_i           data-memory access in MEM and its completion
//   stall_if_o, stall_id_o           hold PC + IF/ID, hold ID/EX sources
//   bubble_ex_o, flush_id_o          NOP into ID/EX, NOP into IF/ID
//   stall_mem_o                      hold EX/MEM and MEM/WB
//   mem_err_o                        one-cycle pulse when a memory access times out
//   state_o                          FSM state (RUN=0, LOAD_STALL=1, MEM_WAIT=2)
//   stall_cycles_o                   saturating count of cycles with stall_if_o (0 when disabled)
module hazard_ctrl #(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [4:0]       id_sel_rs1_i,
  input  logic [4:0]       id_sel_rs2_i,
  input  logic             id_uses_rs1_i,
  input  logic             id_uses_rs2_i,
  input  logic [4:0]       ex_sel_rd_i,
  input  logic             ex_is_load_i,
  input  logic             ex_branch_taken_i,
  input  logic             mem_req_i,
  input  logic             mem_ready_i,
  output logic             stall_if_o,
  output logic             stall_id_o,
  output logic             bubble_ex_o,
  output logic             flush_id_o,
  output logic             stall_mem_o,
  output logic             mem_err_o,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] stall_cycles_o
);

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LOAD_STALL = 2'd1,
    MEM_WAIT   = 2'd2
  } state_t;

  // A zero timeout still needs a one-bit counter to keep the logic well formed.
  localparam int WAIT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((MEM_TIMEOUT > 0) ? (MEM_TIMEOUT - 1) : 0);

  state_t            state, state_nxt;
  logic [WAIT_W-1:0] wait_cnt, wait_cnt_nxt;

  logic luh, use_luh, freeze, timeout;
  logic s_if, s_id, b_ex, f_id, s_mem, err;

  assign luh = ex_is_load_i && (ex_sel_rd_i != 5'd0) &&
               ((id_uses_rs1_i && (id_sel_rs1_i == ex_sel_rd_i)) ||
                (id_uses_rs2_i && (id_sel_rs2_i == ex_sel_rd_i)));

  // The cycle after a load-use stall, EX already holds the bubble, so the
  // same ID/EX pair must not stall a second time.
  assign use_luh = luh && (state != LOAD_STALL);

  // In MEM_WAIT the request is known to be outstanding; only readiness matters.
  assign freeze  = (state == MEM_WAIT) ? !mem_ready_i : (mem_req_i && !mem_ready_i);
  assign timeout = (MEM_TIMEOUT != 0) && (state == MEM_WAIT) && !mem_ready_i &&
                   (wait_cnt == WAIT_LAST);

  always_comb begin
    s_if         = 1'b0;
    s_id         = 1'b0;
    b_ex         = 1'b0;
    f_id         = 1'b0;
    s_mem        = 1'b0;
    err          = 1'b0;
    state_nxt    = RUN;
    wait_cnt_nxt = '0;
    if (timeout) begin
      // Abandon the access and release the pipe; the CSR logic takes the trap.
      err = 1'b1;
    end else if (freeze) begin
      s_if      = 1'b1;
      s_id      = 1'b1;
      s_mem     = 1'b1;
      state_nxt = MEM_WAIT;
      // The entry cycle is the first stalled cycle, so the count starts at 1.
      wait_cnt_nxt = (state == MEM_WAIT) ? (wait_cnt + 1'b1) : WAIT_W'(1);
    end else if (ex_branch_taken_i) begin
      // Any load-use consumer in ID is on the wrong path and is squashed.
      f_id = 1'b1;
      b_ex = 1'b1;
    end else if (use_luh) begin
      s_if      = 1'b1;
      s_id      = 1'b1;
      b_ex      = 1'b1;
      state_nxt = LOAD_STALL;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state    <= RUN;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
    end
  end

  // Inputs may be active while reset is held; keep every control quiet then.
  assign stall_if_o  = rst_ni & s_if;
  assign stall_id_o  = rst_ni & s_id;
  assign bubble_ex_o = rst_ni & b_ex;
  assign flush_id_o  = rst_ni & f_id;
  assign stall_mem_o = rst_ni & s_mem;
  assign mem_err_o   = rst_ni & err;
  assign state_o     = state;

`ifdef HAZARD_CTRL_STALL_COUNT_EN
  logic [CNT_W-1:0] stall_cnt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_cnt <= '0;
    end else if (stall_if_o && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

  assign stall_cycles_o = stall_cnt;
`else
  assign stall_cycles_o = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - directed and randomized self-checking bench for hazard_ctrl
module tb_hazard_ctrl;

  localparam int TO    = 4;
  localparam int CNT_W = 32;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [4:0]       rs1, rs2, rd;
  logic             u1, u2, ld, br, req, rdy;
  logic             stall_if, stall_id, bubble_ex, flush_id, stall_mem, mem_err;
  logic [1:0]       state;
  logic [CNT_W-1:0] stall_cycles;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: "a bubble was just inserted", "waiting on memory" and
  // how many stalled cycles the current access has accumulated.
  bit m_bubble;
  bit m_wait;
  int m_waited;
  int m_stalls;

  hazard_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CNT_W)) dut (
    .clk_i             (clk),
    .rst_ni            (rst_n),
    .id_sel_rs1_i      (rs1),
    .id_sel_rs2_i      (rs2),
    .id_uses_rs1_i     (u1),
    .id_uses_rs2_i     (u2),
    .ex_sel_rd_i       (rd),
    .ex_is_load_i      (ld),
    .ex_branch_taken_i (br),
    .mem_req_i         (req),
    .mem_ready_i       (rdy),
    .stall_if_o        (stall_if),
    .stall_id_o        (stall_id),
    .bubble_ex_o       (bubble_ex),
    .flush_id_o        (flush_id),
    .stall_mem_o       (stall_mem),
    .mem_err_o         (mem_err),
    .state_o           (state),
    .stall_cycles_o    (stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int exp_count();
`ifdef HAZARD_CTRL_STALL_COUNT_EN
    return m_stalls;
`else
    return 0;
`endif
  endfunction

  task automatic model_reset();
    m_bubble = 0;
    m_wait   = 0;
    m_waited = 0;
    m_stalls = 0;
  endtask

  task automatic drive(input logic [4:0] a1, input logic [4:0] a2, input logic e1, input logic e2,
                       input logic [4:0] d, input logic l, input logic b, input logic q, input logic r);
    rs1 = a1; rs2 = a2; u1 = e1; u2 = e2; rd = d; ld = l; br = b; req = q; rdy = r;
  endtask

  // One clock cycle: apply inputs, predict outputs from the model, compare, advance the model.
  task automatic step(input logic [4:0] a1, input logic [4:0] a2, input logic e1, input logic e2,
                      input logic [4:0] d, input logic l, input logic b, input logic q, input logic r);
    bit e_if, e_id, e_bex, e_fid, e_mem, e_err, hz, nb, nw;
    int e_state, nwaited;
    @(negedge clk);
    drive(a1, a2, e1, e2, d, l, b, q, r);
    #1;
    e_if = 0; e_id = 0; e_bex = 0; e_fid = 0; e_mem = 0; e_err = 0;
    nb = 0; nw = 0; nwaited = 0;
    hz = l && (d != 0) && ((e1 && a1 == d) || (e2 && a2 == d)) && !m_bubble;
    e_state = m_wait ? 2 : (m_bubble ? 1 : 0);
    if (m_wait && !r && m_waited == TO - 1) begin
      e_err = 1;
    end else if ((m_wait && !r) || (!m_wait && q && !r)) begin
      e_if = 1; e_id = 1; e_mem = 1;
      nw = 1;
      nwaited = m_waited + 1;
    end else if (b) begin
      e_fid = 1; e_bex = 1;
    end else if (hz) begin
      e_if = 1; e_id = 1; e_bex = 1;
      nb = 1;
    end
    chk("stall_if",  32'(stall_if),  32'(e_if));
    chk("stall_id",  32'(stall_id),  32'(e_id));
    chk("bubble_ex", 32'(bubble_ex), 32'(e_bex));
    chk("flush_id",  32'(flush_id),  32'(e_fid));
    chk("stall_mem", 32'(stall_mem), 32'(e_mem));
    chk("mem_err",   32'(mem_err),   32'(e_err));
    chk("state",     32'(state),     32'(e_state));
    chk("stall_cycles", stall_cycles, 32'(exp_count()));
    chk("inv_flush_and_stall", 32'(flush_id & stall_if), 32'd0);
    chk("inv_mem_and_bubble",  32'(stall_mem & bubble_ex), 32'd0);
    if (e_if) m_stalls++;
    m_bubble = nb;
    m_wait   = nw;
    m_waited = nwaited;
  endtask

  // Assert reset with hazard-provoking inputs and check everything is quiet.
  task automatic reset_mid_run();
    @(negedge clk);
    rst_n = 1'b0;
    drive(5'd5, 5'd5, 1, 1, 5'd5, 1, 1, 1, 0);
    #1;
    chk("rst_stall_if",  32'(stall_if),  32'd0);
    chk("rst_stall_id",  32'(stall_id),  32'd0);
    chk("rst_bubble_ex", 32'(bubble_ex), 32'd0);
    chk("rst_flush_id",  32'(flush_id),  32'd0);
    chk("rst_stall_mem", 32'(stall_mem), 32'd0);
    chk("rst_mem_err",   32'(mem_err),   32'd0);
    chk("rst_state",     32'(state),     32'd0);
    chk("rst_stall_cycles", stall_cycles, 32'd0);
    model_reset();
    @(negedge clk);
    drive(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0);
    model_reset();
    #1;
    chk("reset_state", 32'(state), 32'd0);
    chk("reset_stall_if", 32'(stall_if), 32'd0);
    chk("reset_stall_cycles", stall_cycles, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Load-use: one bubble, then no second stall on the same pair.
    step(5'd5, 5'd0, 1, 0, 5'd5, 1, 0, 0, 1);
    step(5'd5, 5'd0, 1, 0, 5'd5, 1, 0, 0, 1);
    step(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 1);

    // rd=0 and unused source never stall.
    step(5'd0, 5'd0, 1, 0, 5'd0, 1, 0, 0, 1);
    step(5'd0, 5'd7, 0, 0, 5'd7, 1, 0, 0, 1);

    // Taken branch beats a concurrent load-use.
    step(5'd9, 5'd0, 1, 0, 5'd9, 1, 1, 0, 1);
    step(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 1);

    // Three wait cycles, then exit with a pending taken branch.
    step(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 0);
    step(5'd0, 5'd0, 0, 0, 5'd0, 0, 1, 1, 0);
    step(5'd0, 5'd0, 0, 0, 5'd0, 0, 1, 1, 0);
    step(5'd0, 5'd0, 0, 0, 5'd0, 0, 1, 1, 1);
    step(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 1);

    // Load-use held through a wait is acted on in the exit cycle.
    step(5'd3, 5'd0, 1, 0, 5'd3, 1, 0, 1, 0);
    step(5'd3, 5'd0, 1, 0, 5'd3, 1, 0, 1, 1);
    step(5'd3, 5'd0, 1, 0, 5'd3, 1, 0, 0, 1);

    // Timeout: memory never answers.
    for (int i = 0; i < TO; i++) step(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 0);
    step(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 1);

    // Reset in the middle of a wait, then counting restarts from zero.
    step(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 0);
    step(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 0);
    reset_mid_run();
    step(5'd2, 5'd0, 1, 0, 5'd2, 1, 0, 0, 1);
    step(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 1);

    // Randomized traffic over a small register set so hazards collide often.
    for (int i = 0; i < 400; i++) begin
      if (i == 200) reset_mid_run();
      step(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 99) < 15), 1'($urandom_range(0, 99) < 35),
           1'($urandom_range(0, 99) < 45));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
